// File: rtl/read_miss_issuer.sv
`default_nettype none
// ============================================================================
// Module  : read_miss_issuer
// Brief   : Captures read misses, records {id,addr} in the AR FIFO, then
//           issues the read address to memory, capping in-flight misses.
// Revision: 1.0 - initial release
// ============================================================================
module read_miss_issuer #(
    parameter int ADDR_W    = 64,
    parameter int ID_W      = 10,
    parameter int MAX_OUTST = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_valid_i,
    output logic                               miss_ready_o,
    input  logic [ADDR_W-1:0]                  miss_addr_i,
    output logic                               ar_fifo_wren_o,
    input  logic                               ar_fifo_full_i,
    output logic [ID_W+ADDR_W-1:0]             ar_fifo_wdata_o,
    output logic                               mem_arvalid_o,
    input  logic                               mem_arready_i,
    output logic [ADDR_W-1:0]                  mem_araddr_o,
    output logic [ID_W-1:0]                    mem_arid_o,
    input  logic                               done_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]     outstanding_o,
    output logic                               err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        ADDR = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   lat_addr;
    logic [ID_W-1:0]     lat_id;
    logic [ID_W-1:0]     next_id;
    logic [CNT_W-1:0]    outstanding;
    logic                err;
    logic                in_flight_hold;
    logic [CNT_W:0]      committed;
    logic                ar_hs;

    // A captured miss that has not yet handshaken still occupies a slot.
    assign in_flight_hold = (state != IDLE);
    assign committed      = {1'b0, outstanding} + (CNT_W+1)'(in_flight_hold);
    assign ar_hs          = (state == ADDR) && mem_arready_i;

    assign miss_ready_o    = !rst && (state == IDLE) && (committed < MAX_EXT);
    assign ar_fifo_wren_o  = (state == PUSH) && !ar_fifo_full_i;
    assign ar_fifo_wdata_o = {lat_id, lat_addr};
    assign mem_arvalid_o   = (state == ADDR);
    assign mem_araddr_o    = lat_addr;
    assign mem_arid_o      = lat_id;
    assign outstanding_o   = outstanding;
    assign err_o           = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_id      <= '0;
            next_id     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid_i && miss_ready_o) begin
                        lat_addr <= miss_addr_i;
                        lat_id   <= next_id;
                        next_id  <= next_id + ID_W'(1);
                        state    <= PUSH;
                    end
                end
                PUSH: begin
                    if (!ar_fifo_full_i) begin
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_arready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Simultaneous issue and retirement cancel out.
            if (ar_hs && !done_i) begin
                if (outstanding != MAX_CNT) begin
                    outstanding <= outstanding + CNT_W'(1);
                end
            end else if (!ar_hs && done_i) begin
                if (outstanding == '0) begin
                    err <= 1'b1;
                end else begin
                    outstanding <= outstanding - CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_read_miss_issuer.sv
`default_nettype none
// ============================================================================
// Module  : tb_read_miss_issuer
// Brief   : Directed and random stimulus for read_miss_issuer against a
//           transaction-queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_read_miss_issuer;

    localparam int AW    = 16;
    localparam int IW    = 2;
    localparam int MO    = 2;
    localparam int CNT_W = $clog2(MO + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_valid;
    logic              miss_ready;
    logic [AW-1:0]     miss_addr;
    logic              wren;
    logic              fifo_full;
    logic [IW+AW-1:0]  wdata;
    logic              arvalid;
    logic              arready;
    logic [AW-1:0]     araddr;
    logic [IW-1:0]     arid;
    logic              done;
    logic [CNT_W-1:0]  outstanding;
    logic              err;

    always #5 clk = ~clk;

    read_miss_issuer #(
        .ADDR_W    (AW),
        .ID_W      (IW),
        .MAX_OUTST (MO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_valid_i    (miss_valid),
        .miss_ready_o    (miss_ready),
        .miss_addr_i     (miss_addr),
        .ar_fifo_wren_o  (wren),
        .ar_fifo_full_i  (fifo_full),
        .ar_fifo_wdata_o (wdata),
        .mem_arvalid_o   (arvalid),
        .mem_arready_i   (arready),
        .mem_araddr_o    (araddr),
        .mem_arid_o      (arid),
        .done_i          (done),
        .outstanding_o   (outstanding),
        .err_o           (err)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } txn_t;

    // Reference model: misses accepted but not pushed, pushed but not issued.
    txn_t cap_q[$];
    txn_t push_q[$];
    int   m_cnt;
    bit   m_err;
    int   m_next_id;
    int   ncmp  = 0;
    int   nfail = 0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cap_q.delete();
        push_q.delete();
        m_cnt     = 0;
        m_err     = 1'b0;
        m_next_id = 0;
    endtask

    // One clock: entered at posedge+1, drives, checks mid-cycle, advances model.
    task automatic cyc(bit r, bit v, logic [AW-1:0] a, bit f, bit ar, bit d);
        bit   e_ready, e_wren, e_arvalid, acc, hs;
        txn_t t;
        rst = r; miss_valid = v; miss_addr = a; fifo_full = f; arready = ar; done = d;
        #3;
        e_ready   = !r && (cap_q.size() == 0) && (push_q.size() == 0) && (m_cnt < MO);
        e_wren    = (cap_q.size() > 0) && !f;
        e_arvalid = (push_q.size() > 0);
        chk("ready",       128'(miss_ready),  128'(e_ready));
        chk("wren",        128'(wren),        128'(e_wren));
        chk("arvalid",     128'(arvalid),     128'(e_arvalid));
        chk("outstanding", 128'(outstanding), 128'(m_cnt));
        chk("err",         128'(err),         128'(m_err));
        if (e_wren) begin
            chk("wdata", 128'(wdata), 128'({cap_q[0].id, cap_q[0].addr}));
        end
        if (e_arvalid) begin
            chk("araddr", 128'(araddr), 128'(push_q[0].addr));
            chk("arid",   128'(arid),   128'(push_q[0].id));
        end
        acc = v && e_ready;
        hs  = e_arvalid && ar;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (hs) void'(push_q.pop_front());
            if (e_wren) push_q.push_back(cap_q.pop_front());
            if (acc) begin
                t.id   = IW'(m_next_id);
                t.addr = a;
                cap_q.push_back(t);
                m_next_id = (m_next_id + 1) % (1 << IW);
            end
            if (hs && !d) m_cnt++;
            else if (!hs && d) begin
                if (m_cnt == 0) m_err = 1'b1;
                else m_cnt--;
            end
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0;
        fifo_full = 1'b0; arready = 1'b0; done = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, '0, 0, 0, 0);

        // T1 basic: push one cycle after accept, AR one cycle later
        cyc(0, 1, 16'h00AB, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 1);

        // T2 FIFO full for three cycles during PUSH
        cyc(0, 1, 16'h1234, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h5555, 1, 1, 0);
        cyc(0, 1, 16'h5555, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 1);

        // T3 memory backpressure for four cycles
        cyc(0, 1, 16'hBEEF, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h7777, 0, 0, 0);
        cyc(0, 0, '0, 0, 1, 0);

        // T4 cap at two in flight, then issue and retire in the same cycle
        cyc(0, 1, 16'hC001, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'hC002, 0, 1, 0);
        cyc(0, 1, 16'hC003, 0, 1, 1);
        cyc(0, 1, 16'hC003, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 1);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);

        // T5 ID wrap across five misses
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, AW'(16'h0100 + i), 0, 1, 0);
            cyc(0, 0, '0, 0, 1, 0);
            cyc(0, 0, '0, 0, 1, 0);
            cyc(0, 0, '0, 0, 0, 1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), AW'($urandom),
                ($urandom % 4) == 0, ($urandom % 3) != 0,
                (m_cnt > 0) && (($urandom % 3) == 0));
        end
        while (m_cnt > 0) cyc(0, 0, '0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1, 0);

        // T6 reset while AR is stalled, then error on retire at zero
        cyc(0, 1, 16'hD00D, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 1, 16'hE0E0, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
